// File: rtl/br_train_sched_if.sv
// Commit/training bus between the branch commit stage, the training scheduler
// and the predictor table write port.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef PredTableDepth
`define PredTableDepth 16
`endif

interface br_train_sched_if #(
    parameter int ADDR     = `AddrWidth,
    parameter int PRT_D    = `PredTableDepth,
    parameter int SIMBRCOM = 2
);
    localparam int IDX = $clog2(PRT_D);

    logic                     init_;
    logic [SIMBRCOM-1:0]      br_commit_;
    logic [SIMBRCOM-1:0]      br_taken_;
    logic [SIMBRCOM*ADDR-1:0] br_addr;
    logic                     upd_;
    logic [IDX-1:0]           upd_idx;
    logic                     upd_taken;
    logic                     upd_init;
    logic                     busy;
    logic [7:0]               drop_cnt;

    modport master (
        output init_, br_commit_, br_taken_, br_addr,
        input  upd_, upd_idx, upd_taken, upd_init, busy, drop_cnt
    );

    modport slave (
        input  init_, br_commit_, br_taken_, br_addr,
        output upd_, upd_idx, upd_taken, upd_init, busy, drop_cnt
    );
endinterface

// File: rtl/br_train_sched.sv
// Branch predictor training scheduler: sweeps the table to weakly-not-taken
// on init, then drains a queue of committed branch outcomes one write per cycle.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef PredTableDepth
`define PredTableDepth 16
`endif

module br_train_sched #(
    parameter int ADDR     = `AddrWidth,
    parameter int PRT_D    = `PredTableDepth,
    parameter int SIMBRCOM = 2,
    parameter int QDEPTH   = 8
) (
    input  logic          clk,
    input  logic          reset_,
    br_train_sched_if.slave bus
);
    localparam int IDX = $clog2(PRT_D);
    localparam int QW  = $clog2(QDEPTH) + 1;
    localparam int PW  = $clog2(QDEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [IDX-1:0] sweep_r, sweep_s;
    logic [IDX-1:0] q_idx_r   [QDEPTH];
    logic           q_taken_r [QDEPTH];
    logic [PW-1:0]  rd_ptr_r, wr_ptr_r;
    logic [QW-1:0]  occ_r;
    logic [7:0]     drop_r;
    logic           upd_n_r, upd_taken_r, upd_init_r;
    logic [IDX-1:0] upd_idx_r;

    logic           pop_s, wr_s, wr_taken_s, wr_init_s;
    logic [IDX-1:0] wr_idx_s;
    logic [QW-1:0]  free_s, n_push_s;
    logic [7:0]     n_drop_s;
    logic [8:0]     drop_sum_s;
    logic           push_en_s   [SIMBRCOM];
    logic [PW-1:0]  push_slot_s [SIMBRCOM];

    // Next state and the single table write of this cycle (sweep or drain).
    always_comb begin
        state_s    = state_r;
        sweep_s    = sweep_r;
        pop_s      = 1'b0;
        wr_s       = 1'b0;
        wr_idx_s   = '0;
        wr_taken_s = 1'b0;
        wr_init_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                wr_s      = 1'b1;
                wr_idx_s  = sweep_r;
                wr_init_s = 1'b1;
                if (!bus.init_) begin
                    sweep_s = '0;
                end else if (sweep_r == IDX'(PRT_D - 1)) begin
                    state_s = ST_RUN;
                    sweep_s = '0;
                end else begin
                    sweep_s = sweep_r + IDX'(1);
                end
            end
            ST_RUN: begin
                // An init request takes the cycle, so the queue head stays put.
                if (!bus.init_) begin
                    state_s = ST_INIT;
                    sweep_s = '0;
                end else if (occ_r != '0) begin
                    pop_s      = 1'b1;
                    wr_s       = 1'b1;
                    wr_idx_s   = q_idx_r[rd_ptr_r];
                    wr_taken_s = q_taken_r[rd_ptr_r];
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_INIT;
                sweep_s = '0;
            end
        endcase
    end

    // Allocate free slots to valid commit ports in ascending order; the rest drop.
    always_comb begin
        free_s   = QW'(QDEPTH) - occ_r + QW'(pop_s);
        n_push_s = '0;
        n_drop_s = 8'd0;
        for (int i = 0; i < SIMBRCOM; i++) begin
            push_en_s[i]   = 1'b0;
            push_slot_s[i] = wr_ptr_r + n_push_s[PW-1:0];
            if (!bus.br_commit_[i]) begin
                if (n_push_s < free_s) begin
                    push_en_s[i] = 1'b1;
                    n_push_s     = n_push_s + QW'(1);
                end else begin
                    n_drop_s = n_drop_s + 8'd1;
                end
            end else begin
                push_en_s[i] = 1'b0;
            end
        end
        drop_sum_s = {1'b0, drop_r} + {1'b0, n_drop_s};
    end

    // State, queue storage, drop counter and registered write strobe.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_r     <= ST_INIT;
            sweep_r     <= '0;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            occ_r       <= '0;
            drop_r      <= 8'd0;
            upd_n_r     <= 1'b1;
            upd_idx_r   <= '0;
            upd_taken_r <= 1'b0;
            upd_init_r  <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_idx_r[i]   <= '0;
                q_taken_r[i] <= 1'b0;
            end
        end else begin
            state_r <= state_s;
            sweep_r <= sweep_s;
            for (int i = 0; i < SIMBRCOM; i++) begin
                if (push_en_s[i]) begin
                    q_idx_r[push_slot_s[i]]   <= bus.br_addr[i*ADDR+2 +: IDX];
                    q_taken_r[push_slot_s[i]] <= ~bus.br_taken_[i];
                end
            end
            wr_ptr_r    <= wr_ptr_r + n_push_s[PW-1:0];
            rd_ptr_r    <= rd_ptr_r + PW'(pop_s);
            occ_r       <= occ_r + n_push_s - QW'(pop_s);
            drop_r      <= drop_sum_s[8] ? 8'd255 : drop_sum_s[7:0];
            upd_n_r     <= ~wr_s;
            upd_idx_r   <= wr_idx_s;
            upd_taken_r <= wr_taken_s;
            upd_init_r  <= wr_init_s;
        end
    end

    assign bus.upd_      = upd_n_r;
    assign bus.upd_idx   = upd_idx_r;
    assign bus.upd_taken = upd_taken_r;
    assign bus.upd_init  = upd_init_r;
    assign bus.drop_cnt  = drop_r;
    assign bus.busy      = (QW'(QDEPTH) - occ_r) < QW'(SIMBRCOM);
endmodule

// File: tb/tb_br_train_sched.sv
// Directed bench for br_train_sched: init sweep, latency, burst/overflow,
// init with a queued backlog and reset mid-sweep.
module tb_br_train_sched;
    localparam int ADDR     = 32;
    localparam int PRT_D    = 16;
    localparam int SIMBRCOM = 2;
    localparam int QDEPTH   = 8;

    logic clk = 1'b0;
    logic reset_;
    int   check_cnt = 0;
    int   fail_cnt  = 0;

    br_train_sched_if #(.ADDR(ADDR), .PRT_D(PRT_D), .SIMBRCOM(SIMBRCOM)) bif ();

    br_train_sched #(
        .ADDR(ADDR), .PRT_D(PRT_D), .SIMBRCOM(SIMBRCOM), .QDEPTH(QDEPTH)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        bif.init_      = 1'b1;
        bif.br_commit_ = '1;
        bif.br_taken_  = '1;
        bif.br_addr    = '0;
    endtask

    task automatic drive(input int port, input logic [3:0] idx, input logic taken);
        bif.br_commit_[port]             = 1'b0;
        bif.br_taken_[port]              = ~taken;
        bif.br_addr[port*ADDR +: ADDR]   = {16'hABCD, 10'd0, idx, 2'b01};
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".upd_"},  32'(bif.upd_),      32'd1);
        chk({tag, ".idx"},   32'(bif.upd_idx),   32'd0);
        chk({tag, ".taken"}, 32'(bif.upd_taken), 32'd0);
        chk({tag, ".init"},  32'(bif.upd_init),  32'd0);
    endtask

    task automatic chk_sweep(input string tag, input int idx);
        chk({tag, ".upd_"}, 32'(bif.upd_),    32'd0);
        chk({tag, ".init"}, 32'(bif.upd_init), 32'd1);
        chk({tag, ".idx"},  32'(bif.upd_idx),  32'(idx));
    endtask

    task automatic chk_write(input string tag, input int idx, input logic taken);
        chk({tag, ".upd_"},  32'(bif.upd_),      32'd0);
        chk({tag, ".init"},  32'(bif.upd_init),  32'd0);
        chk({tag, ".idx"},   32'(bif.upd_idx),   32'(idx));
        chk({tag, ".taken"}, 32'(bif.upd_taken), 32'(taken));
    endtask

    initial begin
        logic [31:0] kv;

        // Reset values
        reset_ = 1'b0;
        idle_in();
        step();
        step();
        chk_idle("rst");
        chk("rst.drop", 32'(bif.drop_cnt), 32'd0);
        chk("rst.busy", 32'(bif.busy), 32'd0);

        // Full sweep after reset release, then idle
        reset_ = 1'b1;
        for (int i = 0; i < PRT_D; i++) begin
            step();
            chk_sweep($sformatf("sweep0_%0d", i), i);
        end
        step();
        chk_idle("sweep0_end");

        // Single commit latency: addr 0x44 taken on port 0
        bif.br_commit_[0] = 1'b0;
        bif.br_taken_[0]  = 1'b0;
        bif.br_addr[31:0] = 32'h0000_0044;
        step();
        idle_in();
        chk_idle("lat_t1");
        step();
        chk_write("lat_t2", 1, 1'b1);
        step();
        chk_idle("lat_t3");

        // Burst: both ports for 8 cycles; entry k has idx k, taken k[0]; entry 15 drops
        for (int m = 0; m <= 16; m++) begin
            if (m < 8) begin
                kv = 32'(2 * m);
                drive(0, kv[3:0], kv[0]);
                kv = 32'(2 * m + 1);
                drive(1, kv[3:0], kv[0]);
            end else begin
                idle_in();
            end
            step();
            if (m >= 1 && m <= 15) begin
                kv = 32'(m - 1);
                chk_write($sformatf("burst_%0d", m - 1), int'(kv[3:0]), kv[0]);
            end
            if (m == 4)  chk("burst.busy_occ6", 32'(bif.busy), 32'd0);
            if (m == 5)  chk("burst.busy_occ7", 32'(bif.busy), 32'd1);
            if (m == 6)  chk("burst.drop_none", 32'(bif.drop_cnt), 32'd0);
            if (m == 7)  chk("burst.drop_one",  32'(bif.drop_cnt), 32'd1);
            if (m == 16) begin
                chk_idle("burst_end");
                chk("burst.busy_end", 32'(bif.busy), 32'd0);
            end
        end

        // init_ with 3 queued entries: A,B pushed with init_, C pushed during INIT
        drive(0, 4'd3, 1'b1);
        drive(1, 4'd9, 1'b0);
        bif.init_ = 1'b0;
        step();
        chk_idle("init_req");
        idle_in();
        drive(0, 4'd12, 1'b1);
        step();
        chk_sweep("sweep1_0", 0);
        idle_in();
        for (int i = 1; i < PRT_D; i++) begin
            step();
            chk_sweep($sformatf("sweep1_%0d", i), i);
        end
        step();
        chk_write("drain_a", 3, 1'b1);
        step();
        chk_write("drain_b", 9, 1'b0);
        step();
        chk_write("drain_c", 12, 1'b1);
        step();
        chk_idle("drain_end");

        // Reset mid-sweep with 4 entries queued, commits asserted alongside reset
        drive(0, 4'd1, 1'b1);
        drive(1, 4'd2, 1'b1);
        bif.init_ = 1'b0;
        step();
        idle_in();
        drive(0, 4'd4, 1'b0);
        drive(1, 4'd5, 1'b1);
        step();
        chk_sweep("sweep2_0", 0);
        idle_in();
        step();
        chk_sweep("sweep2_1", 1);
        chk("pre_rst.drop", 32'(bif.drop_cnt), 32'd1);
        reset_ = 1'b0;
        drive(0, 4'd6, 1'b1);
        drive(1, 4'd7, 1'b1);
        step();
        chk_idle("mid_rst");
        chk("mid_rst.drop", 32'(bif.drop_cnt), 32'd0);
        chk("mid_rst.busy", 32'(bif.busy), 32'd0);
        reset_ = 1'b1;
        idle_in();
        for (int i = 0; i < PRT_D; i++) begin
            step();
            chk_sweep($sformatf("sweep3_%0d", i), i);
        end
        step();
        chk_idle("sweep3_end");
        step();
        chk_idle("sweep3_empty");

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end
endmodule
